// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Two-requester arbiter/sequencer for the data port of the shared
// instruction/data RAM. Port 0 is the CPU load/store unit, port 1 is the
// boot loader/DMA. One access is in flight at a time, walking through
// IDLE -> ACCESS -> RESP -> IDLE, so at most one access every three cycles.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0/req1             access request, held until the matching gnt pulse
//   we0/we1               1 = write, 0 = read
//   wmask0/wmask1 [3:0]   byte enables for writes
//   addr0/addr1           word address (ADDR_WIDTH bits)
//   wdata0/wdata1 [31:0]  write data
//   gnt0/gnt1             1-cycle pulse: command latched
//   rvalid0/rvalid1       1-cycle pulse: access complete (reads and writes)
//   rdata0/rdata1 [31:0]  read data, held until the next read on that port
//   ram_we/ram_wmask/ram_addr/ram_wdata  registered RAM data-port command
//   ram_rdata [31:0]      RAM read data, one cycle after the address edge
//
// Configuration
//   DMEM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins contention;
//                           otherwise round-robin on the last granted port.
//                           Cycle timing is the same in both builds.
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [3:0]            wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [31:0]           wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [3:0]            wmask1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata0,
    output logic [31:0]           rdata1,
    output logic                  ram_we,
    output logic [3:0]            ram_wmask,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic owner;
    logic we_q;
    logic grant_port;
    logic any_req;
    logic sel_we;
    logic [3:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0] sel_wdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic last_owner;
`endif

    assign any_req = req0 | req1;

    // Arbitration and command select. A lone requester always wins; under
    // contention the round-robin build favours the port not granted last.
    always_comb begin
        grant_port = req0 ? 1'b0 : 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        if (req0 && req1) begin
            grant_port = ~last_owner;
        end
`endif
        sel_we    = grant_port ? we1    : we0;
        sel_wmask = grant_port ? wmask1 : wmask0;
        sel_addr  = grant_port ? addr1  : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed three-step walk once a request is accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch at grant, and response capture at the end of RESP.
    // The RAM address/data/mask registers simply hold between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            we_q       <= 1'b0;
            ram_wmask  <= 4'b0000;
            ram_addr   <= '0;
            ram_wdata  <= 32'd0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= 32'd0;
            rdata1     <= 32'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_owner <= 1'b1;
`endif
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == IDLE && any_req) begin
                owner      <= grant_port;
                we_q       <= sel_we;
                ram_wmask  <= sel_we ? sel_wmask : 4'b0000;
                ram_addr   <= sel_addr;
                ram_wdata  <= sel_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                last_owner <= grant_port;
`endif
            end
            if (state == RESP) begin
                if (!we_q) begin
                    if (owner) begin
                        rdata1 <= ram_rdata;
                    end else begin
                        rdata0 <= ram_rdata;
                    end
                end
                if (owner) begin
                    rvalid1 <= 1'b1;
                end else begin
                    rvalid0 <= 1'b1;
                end
            end
        end
    end

    // Decoded outputs. Because these come straight from the state register,
    // an asynchronous reset during ACCESS removes ram_we immediately.
    always_comb begin
        gnt0   = (state == ACCESS) && !owner;
        gnt1   = (state == ACCESS) &&  owner;
        ram_we = (state == ACCESS) &&  we_q;
    end

endmodule
